// File: rtl/ram_uploader.sv
// ram_uploader
//   Streams a region of SDRAM back to the HPS over the ioctl upload channel.
//   This block is a Wishbone classic-cycle read initiator. It turns 32-bit
//   SDRAM words into 16-bit ioctl words, using a one-word cache. After the
//   upper half of a word has been delivered, it prefetches the next word.
//
// Ports
//   clk_sys     system clock; all logic is on its rising edge
//   reset_n     synchronous active-low reset
//   upload_req  level, high for the whole upload session
//   ioctl_rd    one-cycle strobe, requests the 16-bit word at ioctl_addr
//   ioctl_addr  byte address within the image (bit 0 ignored)
//   ioctl_din   data returned to the HPS
//   ioctl_wait  high while the requested data is not yet valid
//   busy        high while a Wishbone cycle is in flight
//   wb_*        Wishbone read initiator toward the SDRAM controller
module ram_uploader #(
  parameter logic [25:0] BASE_ADDR = 26'h400000,
  parameter int          AW        = 25
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          upload_req,
  input  logic          ioctl_rd,
  input  logic [AW-1:0] ioctl_addr,
  output logic [15:0]   ioctl_din,
  output logic          ioctl_wait,
  output logic          busy,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic          wb_we,
  output logic [3:0]    wb_sel,
  output logic [2:0]    wb_cti,
  output logic [25:0]   wb_adr,
  input  logic [31:0]   wb_dat_i,
  input  logic          wb_ack
);

  localparam int TW = AW - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,     // demand read; with r_cyc low, the cycle is launched next edge
    S_PREFETCH,  // speculative read of the word after the cached one
    S_PENDING    // demand request for another word, queued behind a prefetch
  } state_t;

  state_t          r_state;
  logic [31:0]     r_cache_data;
  logic [TW-1:0]   r_cache_tag;
  logic            r_valid;
  logic [TW-1:0]   r_req_tag;
  logic            r_req_half;
  logic [TW-1:0]   r_pf_tag;
  logic            r_pf_pend;
  logic            r_cyc;
  logic [25:0]     r_adr;
  logic [15:0]     r_din;
  logic            r_wait;

  logic [TW-1:0]   w_rd_tag;
  logic            w_rd_half;
  logic            w_rd_go;
  logic            w_hit;
  logic [TW-1:0]   w_pf_tag;
  logic            w_unused_addr0;

  assign w_rd_tag       = ioctl_addr[AW-1:2];
  assign w_rd_half      = ioctl_addr[1];
  assign w_rd_go        = ioctl_rd && upload_req;
  assign w_hit          = r_valid && (r_cache_tag == w_rd_tag);
  assign w_pf_tag       = r_cache_tag + TW'(1);   // wraps at 2^(AW-2)
  assign w_unused_addr0 = ioctl_addr[0];

  // Tag to SDRAM byte address, modulo 2^26.
  function automatic logic [25:0] map_adr(input logic [TW-1:0] tag);
    return BASE_ADDR + 26'({tag, 2'b00});
  endfunction

  // Little-endian half select.
  function automatic logic [15:0] half_sel(input logic [31:0] word, input logic upper);
    return upper ? word[31:16] : word[15:0];
  endfunction

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cache_data <= '0;
      r_cache_tag  <= '0;
      r_valid      <= 1'b0;
      r_req_tag    <= '0;
      r_req_half   <= 1'b0;
      r_pf_tag     <= '0;
      r_pf_pend    <= 1'b0;
      r_cyc        <= 1'b0;
      r_adr        <= BASE_ADDR;
      r_din        <= '0;
      r_wait       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A demand read takes priority over a queued prefetch launch.
          if (w_rd_go) begin
            if (w_hit) begin
              r_din     <= half_sel(r_cache_data, w_rd_half);
              r_pf_pend <= w_rd_half;
            end else begin
              r_cyc      <= 1'b1;
              r_adr      <= map_adr(w_rd_tag);
              r_req_tag  <= w_rd_tag;
              r_req_half <= w_rd_half;
              r_wait     <= 1'b1;
              r_pf_pend  <= 1'b0;
              r_state    <= S_FETCH;
            end
          end else if (r_pf_pend && upload_req) begin
            r_pf_pend <= 1'b0;
            r_cyc     <= 1'b1;
            r_adr     <= map_adr(w_pf_tag);
            r_pf_tag  <= w_pf_tag;
            r_state   <= S_PREFETCH;
          end
        end

        S_FETCH: begin
          if (!r_cyc) begin
            // Deferred launch after a prefetch. Waiting here keeps cyc
            // low for one clock between the two cycles.
            if (!upload_req) begin
              r_wait  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cyc <= 1'b1;
              r_adr <= map_adr(r_req_tag);
            end
          end else if (wb_ack) begin
            r_cyc   <= 1'b0;
            r_wait  <= 1'b0;
            r_state <= S_IDLE;
            if (upload_req) begin
              r_cache_data <= wb_dat_i;
              r_cache_tag  <= r_req_tag;
              r_valid      <= 1'b1;
              r_din        <= half_sel(wb_dat_i, r_req_half);
              r_pf_pend    <= r_req_half;
            end
          end
        end

        S_PREFETCH: begin
          if (wb_ack) begin
            r_cyc   <= 1'b0;
            r_state <= S_IDLE;
            // Overwriting the cache is safe here: the upper half of the
            // previous word has already been handed out.
            if (upload_req) begin
              r_cache_data <= wb_dat_i;
              r_cache_tag  <= r_pf_tag;
              r_valid      <= 1'b1;
            end
            if (w_rd_go) begin
              if (w_rd_tag == r_pf_tag) begin
                r_din     <= half_sel(wb_dat_i, w_rd_half);
                r_pf_pend <= w_rd_half;
              end else begin
                r_req_tag  <= w_rd_tag;
                r_req_half <= w_rd_half;
                r_wait     <= 1'b1;
                r_state    <= S_FETCH;
              end
            end
          end else if (w_rd_go) begin
            // The demand request either rides on the in-flight prefetch, or
            // it is queued until the prefetch completes.
            r_req_tag  <= w_rd_tag;
            r_req_half <= w_rd_half;
            r_wait     <= 1'b1;
            r_state    <= (w_rd_tag == r_pf_tag) ? S_FETCH : S_PENDING;
          end
        end

        S_PENDING: begin
          if (wb_ack) begin
            r_cyc <= 1'b0;
            if (!upload_req) begin
              r_wait  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cache_data <= wb_dat_i;
              r_cache_tag  <= r_pf_tag;
              r_valid      <= 1'b1;
              if (r_req_tag == r_pf_tag) begin
                r_din     <= half_sel(wb_dat_i, r_req_half);
                r_pf_pend <= r_req_half;
                r_wait    <= 1'b0;
                r_state   <= S_IDLE;
              end else begin
                r_state <= S_FETCH;
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase

      // Outside a session nothing is cached and no prefetch may be queued.
      if (!upload_req) begin
        r_valid   <= 1'b0;
        r_pf_pend <= 1'b0;
      end
    end
  end

  assign ioctl_din  = r_din;
  assign ioctl_wait = r_wait;
  assign busy       = r_cyc;
  assign wb_cyc     = r_cyc;
  assign wb_stb     = r_cyc;
  assign wb_we      = 1'b0;
  assign wb_sel     = 4'b1111;
  assign wb_cti     = 3'b000;
  assign wb_adr     = r_adr;

endmodule

// File: tb/tb_ram_uploader.sv
module tb_ram_uploader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        upload_req;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_din;
  logic        ioctl_wait, busy, wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic [25:0] wb_adr;
  logic [31:0] wb_dat_i;
  logic        wb_ack;

  // second instance, used only for the address wrap check
  logic        w2_rd;
  logic [24:0] w2_addr;
  logic [15:0] w2_din;
  logic        w2_wait, w2_busy, w2_cyc, w2_stb, w2_we;
  logic [3:0]  w2_sel;
  logic [2:0]  w2_cti;
  logic [25:0] w2_adr;
  logic [31:0] w2_dat;
  logic        w2_ack;

  int n_vec = 0;
  int n_err = 0;
  int ack_delay = 4;
  int ack_cnt = 0;
  logic [15:0] last_din;

  logic [15:0] exp_din[$];
  logic [25:0] exp_adr[$];

  always #5 clk_sys = ~clk_sys;

  ram_uploader u_dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .upload_req(upload_req),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .busy(busy), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
    .wb_we(wb_we), .wb_sel(wb_sel), .wb_cti(wb_cti), .wb_adr(wb_adr),
    .wb_dat_i(wb_dat_i), .wb_ack(wb_ack)
  );

  ram_uploader #(.BASE_ADDR(26'h3FFFFFC), .AW(25)) u_wrap (
    .clk_sys(clk_sys), .reset_n(reset_n), .upload_req(upload_req),
    .ioctl_rd(w2_rd), .ioctl_addr(w2_addr), .ioctl_din(w2_din),
    .ioctl_wait(w2_wait), .busy(w2_busy), .wb_cyc(w2_cyc), .wb_stb(w2_stb),
    .wb_we(w2_we), .wb_sel(w2_sel), .wb_cti(w2_cti), .wb_adr(w2_adr),
    .wb_dat_i(w2_dat), .wb_ack(w2_ack)
  );

  function automatic logic [31:0] mem_word(input logic [25:0] a);
    if (a == 26'h400000) return 32'hDEADBEEF;
    return ({6'd0, a} * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic logic [15:0] lo(input logic [25:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return w[15:0];
  endfunction

  function automatic logic [15:0] hi(input logic [25:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return w[31:16];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // SDRAM responders
  always @(posedge clk_sys) begin
    if (wb_ack) begin
      wb_ack  <= 1'b0;
      ack_cnt <= 0;
    end else if (wb_cyc) begin
      if (ack_cnt >= ack_delay) begin
        wb_ack   <= 1'b1;
        wb_dat_i <= mem_word(wb_adr);
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end else begin
      ack_cnt <= 0;
    end
  end

  always @(posedge clk_sys) begin
    if (w2_ack) w2_ack <= 1'b0;
    else if (w2_cyc) begin
      w2_ack <= 1'b1;
      w2_dat <= mem_word(w2_adr);
    end
  end

  // Wishbone monitor: cycle addresses against the scoreboard, address stability
  logic        prev_cyc = 1'b0;
  logic [25:0] cyc_adr;
  logic        adr_moved = 1'b0;
  always @(negedge clk_sys) begin
    if (wb_cyc && !prev_cyc) begin
      cyc_adr   = wb_adr;
      adr_moved = 1'b0;
      check_eq("cyc_expected", 32'(exp_adr.size() > 0), 32'd1);
      if (exp_adr.size() > 0) check_eq("wb_adr", 32'(wb_adr), 32'(exp_adr.pop_front()));
    end else if (wb_cyc && wb_adr != cyc_adr) begin
      adr_moved = 1'b1;
    end
    if (wb_ack) check_eq("adr_stable", 32'(adr_moved), 32'd0);
    prev_cyc = wb_cyc;
  end

  // Called at a negedge; returns at a negedge with the read delivered.
  task automatic do_read(input logic [24:0] addr, input logic [15:0] exp,
                         input int exp_wcyc, input string tag);
    int n;
    logic [15:0] e;
    exp_din.push_back(exp);
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    n = 0;
    while (ioctl_wait && n < 200) begin
      n++;
      @(negedge clk_sys);
    end
    check_eq({tag, "_done"}, 32'(n < 200), 32'd1);
    if (exp_wcyc >= 0) check_eq({tag, "_wait_clks"}, 32'(n), 32'(exp_wcyc));
    e = exp_din.pop_front();
    check_eq({tag, "_din"}, 32'(ioctl_din), 32'(e));
    last_din = e;
  endtask

  task automatic wait_cyc(input logic level, input string tag);
    int n;
    n = 0;
    while (wb_cyc !== level && n < 100) begin
      n++;
      @(negedge clk_sys);
    end
    check_eq(tag, 32'(wb_cyc), 32'(level));
  endtask

  initial begin
    int n;
    reset_n    = 1'b0;
    upload_req = 1'b1;
    ioctl_rd   = 1'b0;
    ioctl_addr = '0;
    w2_rd      = 1'b0;
    w2_addr    = '0;
    wb_ack     = 1'b0;
    wb_dat_i   = '0;
    w2_ack     = 1'b0;
    w2_dat     = '0;

    // Reset
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check_eq("rst_cyc", 32'(wb_cyc), 32'd0);
    check_eq("rst_stb", 32'(wb_stb), 32'd0);
    check_eq("rst_wait", 32'(ioctl_wait), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_din", 32'(ioctl_din), 32'd0);
    check_eq("rst_adr", 32'(wb_adr), 32'h400000);
    check_eq("rst_const", {23'd0, wb_we, wb_sel, wb_cti}, {23'd0, 1'b0, 4'b1111, 3'b000});
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Cold read: miss, ack 5 clocks after cyc rises
    ack_delay = 4;
    exp_adr.push_back(26'h400000);
    do_read(25'h0, 16'hBEEF, 6, "cold");

    // Upper-half hit, then prefetch of the next word
    exp_adr.push_back(26'h400004);
    do_read(25'h2, 16'hDEAD, 0, "hit_hi");
    wait_cyc(1'b1, "pf_start");
    check_eq("pf_busy", 32'(busy), 32'd1);
    check_eq("pf_no_wait", 32'(ioctl_wait), 32'd0);
    wait_cyc(1'b0, "pf_end");
    do_read(25'h4, lo(26'h400004), 0, "pf_hit");

    // Mismatch during prefetch -> queued demand fetch
    ack_delay = 6;
    exp_adr.push_back(26'h400008);
    do_read(25'h6, hi(26'h400004), 0, "hit_hi2");
    wait_cyc(1'b1, "pf2_start");
    exp_adr.push_back(26'h400100);
    do_read(25'h100, lo(26'h400100), -1, "pending");

    // Demand read matching the in-flight prefetch
    exp_adr.push_back(26'h400104);
    do_read(25'h102, hi(26'h400100), 0, "hit_hi3");
    wait_cyc(1'b1, "pf3_start");
    do_read(25'h104, lo(26'h400104), -1, "pf_match");

    // Abort: upload_req drops 2 clocks into a fetch
    ack_delay = 5;
    exp_adr.push_back(26'h400200);
    ioctl_addr = 25'h200;
    ioctl_rd   = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    check_eq("abort_wait_hi", 32'(ioctl_wait), 32'd1);
    repeat (2) @(negedge clk_sys);
    upload_req = 1'b0;
    @(negedge clk_sys);
    check_eq("abort_cyc_held", 32'(wb_cyc), 32'd1);
    wait_cyc(1'b0, "abort_cyc_end");
    check_eq("abort_wait_lo", 32'(ioctl_wait), 32'd0);
    check_eq("abort_din_kept", 32'(ioctl_din), 32'(last_din));

    // Read ignored while upload_req is low
    ioctl_addr = 25'h104;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_eq("idle_rd_cyc", 32'(wb_cyc), 32'd0);
    check_eq("idle_rd_wait", 32'(ioctl_wait), 32'd0);

    // New session: previous word must miss
    upload_req = 1'b1;
    @(negedge clk_sys);
    exp_adr.push_back(26'h400200);
    do_read(25'h200, lo(26'h400200), 7, "resume");
    check_eq("adr_q_empty", 32'(exp_adr.size()), 32'd0);

    // Wrap: BASE 0x3FFFFFC, addr 4 -> SDRAM address 0
    w2_addr = 25'h4;
    w2_rd   = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    w2_rd = 1'b0;
    check_eq("wrap_cyc", 32'(w2_cyc), 32'd1);
    check_eq("wrap_adr", 32'(w2_adr), 32'd0);
    n = 0;
    while (w2_wait && n < 50) begin
      n++;
      @(negedge clk_sys);
    end
    check_eq("wrap_din", 32'(w2_din), 32'(lo(26'h0)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
